// File: rtl/bsg_manycore_pkg.sv
// Shared types for the pod tag master: FSM/field state enum and a small width helper.
package bsg_manycore_pkg;

    typedef enum logic [2:0] {
        TAG_IDLE    = 3'd0,
        TAG_START   = 3'd1,
        TAG_ID      = 3'd2,
        TAG_DNR     = 3'd3,
        TAG_LEN     = 3'd4,
        TAG_PAYLOAD = 3'd5,
        TAG_GAP     = 3'd6,
        TAG_AUTO    = 3'd7
    } tag_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_manycore_pod_tag_serializer.sv
// Field shift/count datapath: frames one latched command onto the registered tag line.
// State and field counter are exposed on o_state/o_next_idle for the top and for checkers.
module bsg_manycore_pod_tag_serializer
    import bsg_manycore_pkg::*;
#(
    parameter int node_id_width_p = 4,
    parameter int len_width_p     = 3,
    parameter int payload_width_p = 1,
    parameter int gap_cycles_p    = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_load,
    input  logic [node_id_width_p-1:0] i_node_id,
    input  logic                       i_data_not_reset,
    input  logic [payload_width_p-1:0] i_payload,
    output logic                       o_tag_data,
    output logic                       o_next_idle,
    output tag_state_e                 o_state
);

    localparam int MAX_FIELD = max_int(max_int(node_id_width_p, len_width_p),
                                       max_int(payload_width_p, gap_cycles_p));
    localparam int CW = $clog2(MAX_FIELD) + 1;
    localparam logic [len_width_p-1:0] LEN_VAL = len_width_p'(payload_width_p);

    tag_state_e                 r_state;
    tag_state_e                 w_next_state;
    logic [CW-1:0]              r_cnt;
    logic [CW-1:0]              w_next_cnt;
    logic [node_id_width_p-1:0] r_node_id;
    logic                       r_dnr;
    logic [payload_width_p-1:0] r_payload;
    logic                       r_tag_data;
    logic                       w_tag_next;
    logic                       w_last;
    int                         w_field_len;
    logic [node_id_width_p-1:0] w_id_sh;
    logic [len_width_p-1:0]     w_len_sh;
    logic [payload_width_p-1:0] w_pay_sh;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= TAG_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_field_len = 1;
        case (r_state)
            TAG_ID:      w_field_len = node_id_width_p;
            TAG_LEN:     w_field_len = len_width_p;
            TAG_PAYLOAD: w_field_len = payload_width_p;
            TAG_GAP:     w_field_len = gap_cycles_p;
            default:     w_field_len = 1;
        endcase
    end

    assign w_last = (r_cnt == CW'(w_field_len - 1));

    // The counter restarts at zero on every field change, so it is also the bit index.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + CW'(1);
        if (r_state == TAG_IDLE) begin
            w_next_cnt = '0;
            if (i_load) w_next_state = TAG_START;
        end else if (w_last) begin
            w_next_cnt = '0;
            case (r_state)
                TAG_START:   w_next_state = TAG_ID;
                TAG_ID:      w_next_state = TAG_DNR;
                TAG_DNR:     w_next_state = TAG_LEN;
                TAG_LEN:     w_next_state = TAG_PAYLOAD;
                TAG_PAYLOAD: w_next_state = TAG_GAP;
                default:     w_next_state = TAG_IDLE;
            endcase
        end
    end

    assign w_id_sh  = r_node_id >> w_next_cnt;
    assign w_len_sh = LEN_VAL >> w_next_cnt;
    assign w_pay_sh = r_payload >> w_next_cnt;

    // Bit for the upcoming cycle; registering it keeps the tag line glitch-free.
    always_comb begin
        w_tag_next = 1'b0;
        case (w_next_state)
            TAG_START:   w_tag_next = 1'b1;
            TAG_ID:      w_tag_next = w_id_sh[0];
            TAG_DNR:     w_tag_next = r_dnr;
            TAG_LEN:     w_tag_next = w_len_sh[0];
            TAG_PAYLOAD: w_tag_next = r_dnr ? w_pay_sh[0] : 1'b1;
            default:     w_tag_next = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_data <= 1'b0;
            r_node_id  <= '0;
            r_dnr      <= 1'b0;
            r_payload  <= '0;
        end else begin
            r_tag_data <= w_tag_next;
            if ((r_state == TAG_IDLE) && i_load) begin
                r_node_id <= i_node_id;
                r_dnr     <= i_data_not_reset;
                r_payload <= i_payload;
            end
        end
    end

    assign o_tag_data  = r_tag_data;
    assign o_next_idle = (w_next_state == TAG_IDLE);
    assign o_state     = r_state;

endmodule

// File: rtl/bsg_manycore_pod_tag_master.sv
// Serial bsg_tag master for the pod array: command handshake plus optional power-on
// auto-reset sequencer, enabled by BSG_MANYCORE_POD_TAG_MASTER_AUTO_RESET_EN.
// Handshake: a command transfers on the rising edge where cmd_v_i & cmd_ready_o; cmd_v_i
// may drop without a transfer, and inputs are ignored while cmd_ready_o is low.
module bsg_manycore_pod_tag_master
    import bsg_manycore_pkg::*;
#(
    parameter int num_nodes_p     = 1,
    parameter int node_id_width_p = 1,
    parameter int len_width_p     = 3,
    parameter int payload_width_p = 1,
    parameter int gap_cycles_p    = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       cmd_v_i,
    input  logic [node_id_width_p-1:0] cmd_node_id_i,
    input  logic                       cmd_data_not_reset_i,
    input  logic [payload_width_p-1:0] cmd_payload_i,
    output logic                       cmd_ready_o,
    output logic                       tag_data_o,
    output logic                       busy_o
);

    typedef struct packed {
        logic [node_id_width_p-1:0] node_id;
        logic                       data_not_reset;
        logic [payload_width_p-1:0] payload;
    } cmd_s;

    if ((node_id_width_p < $clog2(num_nodes_p)) ||
        (payload_width_p > (1 << len_width_p) - 1)) begin : g_cfg_check
        $error("bsg_manycore_pod_tag_master: field widths cannot carry the configuration");
    end

    cmd_s       w_cmd;
    logic       w_load;
    logic       w_ser_idle;
    logic       w_ser_next_idle;
    logic       w_auto_active_nxt;
    tag_state_e w_ser_state;
    logic       r_cmd_ready;
    logic       r_busy;

    assign w_ser_idle = (w_ser_state == TAG_IDLE);

`ifdef BSG_MANYCORE_POD_TAG_MASTER_AUTO_RESET_EN
    localparam logic [1:0] PHASE_CLIENT_RESET = 2'd0;
    localparam logic [1:0] PHASE_ASSERT       = 2'd1;
    localparam logic [1:0] PHASE_DEASSERT     = 2'd2;
    localparam logic [node_id_width_p-1:0] LAST_NODE = node_id_width_p'(num_nodes_p - 1);

    logic                       r_auto_active;
    logic [1:0]                 r_phase;
    logic [node_id_width_p-1:0] r_node;
    logic                       w_auto_fire;
    logic                       w_auto_last;

    assign w_auto_fire       = r_auto_active && w_ser_idle;
    assign w_auto_last       = (r_phase == PHASE_DEASSERT) && (r_node == LAST_NODE);
    assign w_auto_active_nxt = r_auto_active && !(w_auto_fire && w_auto_last);

    always_comb begin
        w_load = w_auto_fire || (cmd_v_i && r_cmd_ready && w_ser_idle);
        w_cmd  = {cmd_node_id_i, cmd_data_not_reset_i, cmd_payload_i};
        if (r_auto_active) begin
            w_cmd.node_id        = r_node;
            w_cmd.data_not_reset = (r_phase != PHASE_CLIENT_RESET);
            w_cmd.payload        = {payload_width_p{r_phase == PHASE_ASSERT}};
        end
    end

    // Walks nodes 0..N-1 once per phase: client reset, pod reset on, pod reset off.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_auto_active <= 1'b1;
            r_phase       <= PHASE_CLIENT_RESET;
            r_node        <= '0;
        end else if (w_auto_fire) begin
            if (w_auto_last) r_auto_active <= 1'b0;
            if (r_node == LAST_NODE) begin
                r_node  <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_node <= r_node + node_id_width_p'(1);
            end
        end
    end
`else
    assign w_load            = cmd_v_i && r_cmd_ready && w_ser_idle;
    assign w_cmd             = {cmd_node_id_i, cmd_data_not_reset_i, cmd_payload_i};
    assign w_auto_active_nxt = 1'b0;
`endif

    // Ready and busy are registered from next-cycle state so both read low during reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_ready <= w_ser_next_idle && !w_auto_active_nxt;
            r_busy      <= !w_ser_next_idle || w_auto_active_nxt;
        end
    end

    bsg_manycore_pod_tag_serializer #(
        .node_id_width_p (node_id_width_p),
        .len_width_p     (len_width_p),
        .payload_width_p (payload_width_p),
        .gap_cycles_p    (gap_cycles_p)
    ) u_serializer (
        .i_clk            (clk_i),
        .i_rst_n          (reset_n_i),
        .i_load           (w_load),
        .i_node_id        (w_cmd.node_id),
        .i_data_not_reset (w_cmd.data_not_reset),
        .i_payload        (w_cmd.payload),
        .o_tag_data       (tag_data_o),
        .o_next_idle      (w_ser_next_idle),
        .o_state          (w_ser_state)
    );

    assign cmd_ready_o = r_cmd_ready;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_bsg_manycore_pod_tag_master.sv
// Bench for bsg_manycore_pod_tag_master: the expected tag line is a queue of bits built
// from each accepted command's frame; ready/busy follow from whether that queue is empty.
module tb_bsg_manycore_pod_tag_master;

    localparam int NN      = 12;
    localparam int NID     = 4;
    localparam int LENW    = 3;
    localparam int PAYW    = 1;
    localparam int GAP     = 2;
    localparam int PKT_LEN = 1 + NID + 1 + LENW + PAYW;

    logic            clk_i = 1'b0;
    logic            reset_n_i = 1'b0;
    logic            cmd_v_i = 1'b0;
    logic [NID-1:0]  cmd_node_id_i = '0;
    logic            cmd_data_not_reset_i = 1'b0;
    logic [PAYW-1:0] cmd_payload_i = '0;
    logic            cmd_ready_o;
    logic            tag_data_o;
    logic            busy_o;

    logic [0:0]      exp_q[$];
    int              n_tests = 0;
    int              n_fail = 0;
    logic            obs_ready;
    logic [11:0]     cap;
    int              k;
    int              highs;

    bsg_manycore_pod_tag_master #(
        .num_nodes_p     (NN),
        .node_id_width_p (NID),
        .len_width_p     (LENW),
        .payload_width_p (PAYW),
        .gap_cycles_p    (GAP)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .cmd_v_i              (cmd_v_i),
        .cmd_node_id_i        (cmd_node_id_i),
        .cmd_data_not_reset_i (cmd_data_not_reset_i),
        .cmd_payload_i        (cmd_payload_i),
        .cmd_ready_o          (cmd_ready_o),
        .tag_data_o           (tag_data_o),
        .busy_o               (busy_o)
    );

    // Clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference frame: start, id LSB first, dnr, length, payload (all ones for dnr=0), gap.
    task automatic push_frame(input logic [NID-1:0] id, input logic dnr, input logic [PAYW-1:0] pay);
        exp_q.push_back(1'b1);
        for (int i = 0; i < NID; i++) exp_q.push_back(id[i]);
        exp_q.push_back(dnr);
        for (int i = 0; i < LENW; i++) exp_q.push_back(1'((PAYW >> i) & 1));
        for (int i = 0; i < PAYW; i++) exp_q.push_back(dnr ? pay[i] : 1'b1);
        for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
    endtask

    task automatic after_release();
`ifdef BSG_MANYCORE_POD_TAG_MASTER_AUTO_RESET_EN
        for (int n = 0; n < NN; n++) push_frame(NID'(n), 1'b0, '0);
        for (int n = 0; n < NN; n++) push_frame(NID'(n), 1'b1, '1);
        for (int n = 0; n < NN; n++) push_frame(NID'(n), 1'b1, '0);
`endif
    endtask

    // Driver: compare at the falling edge, then present inputs for the next rising edge.
    task automatic step(input logic v, input logic [NID-1:0] id, input logic dnr, input logic [PAYW-1:0] pay);
        logic exp_ready;
        logic exp_bit;
        @(negedge clk_i);
        exp_ready = (exp_q.size() == 0);
        exp_bit   = exp_ready ? 1'b0 : exp_q.pop_front();
        check("tag_data", tag_data_o, exp_bit);
        check("cmd_ready", cmd_ready_o, exp_ready);
        check("busy", busy_o, !exp_ready);
        obs_ready            = cmd_ready_o;
        cmd_v_i              = v;
        cmd_node_id_i        = id;
        cmd_data_not_reset_i = dnr;
        cmd_payload_i        = pay;
        if (v && exp_ready) push_frame(id, dnr, pay);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic send_and_capture(input logic [NID-1:0] id, input logic dnr, input logic [PAYW-1:0] pay);
        step(1'b1, id, dnr, pay);
        cap = '0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b0, '0);
            cap = {cap[10:0], tag_data_o};
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_tag", tag_data_o, 1'b0);
        check("reset_ready", cmd_ready_o, 1'b0);
        check("reset_busy", busy_o, 1'b0);
        reset_n_i = 1'b1;
        after_release();
        drain();

        send_and_capture(4'd5, 1'b1, 1'b1);
        check("seq_id5_data", cap, 12'b1101_0110_0100);
        send_and_capture(4'd0, 1'b0, 1'b0);
        check("seq_id0_reset", cap, 12'b1000_0010_0100);
        step(1'b0, '0, 1'b0, '0);

        // Two commands with valid held high: second goes in exactly one frame later.
        step(1'b1, 4'd9, 1'b1, 1'b0);
        for (k = 1; k <= 30; k++) begin
            step(1'b1, 4'd6, 1'b1, 1'b1);
            if (obs_ready) break;
        end
        check("b2b_accept_gap", k, PKT_LEN + GAP + 1);
        step(1'b0, '0, 1'b0, '0);
        drain();

        // Valid pulses while busy must not produce another packet.
        step(1'b1, 4'd5, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step((i == 4) || (i == 7), 4'd3, 1'b0, 1'b0);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b0, '0);
            highs += int'(tag_data_o);
        end
        check("busy_pulse_no_packet", highs, 0);

        // Asynchronous reset in the middle of an all-ones node id.
        step(1'b1, 4'd15, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        #2 reset_n_i = 1'b0;
        #1;
        check("async_rst_tag", tag_data_o, 1'b0);
        check("async_rst_ready", cmd_ready_o, 1'b0);
        check("async_rst_busy", busy_o, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("in_rst_tag", tag_data_o, 1'b0);
        check("in_rst_ready", cmd_ready_o, 1'b0);
        reset_n_i = 1'b1;
        after_release();
        drain();
        send_and_capture(4'd5, 1'b1, 1'b1);
        check("post_rst_seq", cap, 12'b1101_0110_0100);

        // Randomized traffic with random fields every cycle.
        for (int c = 0; c < 700; c++) begin
            step($urandom_range(0, 3) == 0, NID'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), PAYW'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
